// File: rtl/mem_stage_bus_pkg.sv
// Shared encodings and small decode helpers for the memory-access stage.
package mem_stage_bus_pkg;

   localparam logic [3:0] MEMOP_NONE = 4'd0;
   localparam logic [3:0] MEMOP_LB   = 4'd1;
   localparam logic [3:0] MEMOP_LBU  = 4'd2;
   localparam logic [3:0] MEMOP_LH   = 4'd3;
   localparam logic [3:0] MEMOP_LHU  = 4'd4;
   localparam logic [3:0] MEMOP_LW   = 4'd5;
   localparam logic [3:0] MEMOP_SB   = 4'd6;
   localparam logic [3:0] MEMOP_SH   = 4'd7;
   localparam logic [3:0] MEMOP_SW   = 4'd8;

   localparam logic        RstEnable  = 1'b0;
   localparam logic [31:0] ZeroWord   = 32'h0000_0000;
   localparam logic [4:0]  NOPRegAddr = 5'b00000;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic logic is_mem_op(input logic [3:0] op);
      return (op >= MEMOP_LB) && (op <= MEMOP_SW);
   endfunction

   function automatic logic is_load_op(input logic [3:0] op);
      return (op >= MEMOP_LB) && (op <= MEMOP_LW);
   endfunction

   function automatic logic [1:0] memop_size(input logic [3:0] op);
      case (op)
         MEMOP_LB, MEMOP_LBU, MEMOP_SB: return SZ_BYTE;
         MEMOP_LH, MEMOP_LHU, MEMOP_SH: return SZ_HALF;
         default:                       return SZ_WORD;
      endcase
   endfunction

endpackage

// File: rtl/mem_stage_bus_load_align.sv
// Picks the addressed lane out of the load buffer and sign/zero extends it.
module mem_stage_bus_load_align
   import mem_stage_bus_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int OFF_W  = $clog2(DATA_W / 8)
) (
   input  logic [DATA_W-1:0] ld_buf,
   input  logic [OFF_W-1:0]  off,
   input  logic [3:0]        memop,
   output logic [DATA_W-1:0] ld_data
);

   logic [OFF_W-1:0] word_off;
   logic [7:0]       lane_b;
   logic [15:0]      lane_h;
   logic [31:0]      lane_w;

   // Lane extraction by byte offset, then extension chosen by the opcode.
   always_comb begin
      word_off      = off;
      word_off[1:0] = 2'b00;
      lane_b        = ld_buf[{off, 3'b000} +: 8];
      lane_h        = ld_buf[{off, 3'b000} +: 16];
      lane_w        = ld_buf[{word_off, 3'b000} +: 32];
      ld_data       = '0;
      case (memop)
         MEMOP_LB:  ld_data = DATA_W'($signed(lane_b));
         MEMOP_LBU: ld_data = DATA_W'(lane_b);
         MEMOP_LH:  ld_data = DATA_W'($signed(lane_h));
         MEMOP_LHU: ld_data = DATA_W'(lane_h);
         MEMOP_LW:  ld_data = DATA_W'(lane_w);
         default:   ld_data = '0;
      endcase
   end

endmodule

// File: rtl/mem_stage_bus.sv
// Memory-access pipeline stage: ALU passthrough, or one req/ack bus
// transaction per load/store with alignment check and timeout.
//
//  state | meaning
//  IDLE  | no transaction; passthrough, misalign check, issue on aligned op
//  BUSY  | mem_req_o high, waiting for ack or timeout, pipeline stalled
//  DONE  | result/exception presented to write-back for one cycle
module mem_stage_bus
   import mem_stage_bus_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int REG_AW  = 5,
   parameter int TIMEOUT = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_AW-1:0]     wd_i,
   input  logic                  wreg_i,
   input  logic [DATA_W-1:0]     wdata_i,
   input  logic [3:0]            memop_i,
   input  logic [ADDR_W-1:0]     maddr_i,
   input  logic [DATA_W-1:0]     sdata_i,
   output logic [REG_AW-1:0]     wd_o,
   output logic                  wreg_o,
   output logic [DATA_W-1:0]     wdata_o,
   output logic                  stallreq_o,
   output logic                  excpt_o,
   output logic                  mem_req_o,
   output logic                  mem_we_o,
   output logic [ADDR_W-1:0]     mem_addr_o,
   output logic [DATA_W/8-1:0]   mem_sel_o,
   output logic [DATA_W-1:0]     mem_wdata_o,
   input  logic [DATA_W-1:0]     mem_rdata_i,
   input  logic                  mem_ack_i
);

   localparam int SEL_W = DATA_W / 8;
   localparam int OFF_W = $clog2(SEL_W);
   localparam int CNT_W = $clog2(TIMEOUT) + 1;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic               err;
   logic [DATA_W-1:0]  ld_buf;
   logic [DATA_W-1:0]  ld_data;

   logic [OFF_W-1:0]   off, word_off;
   logic [1:0]         size;
   logic               mem_op, misalign;
   logic [SEL_W-1:0]   sel_calc;
   logic [DATA_W-1:0]  wdata_calc;
   logic               issue, ack_take, tmo_hit;

   assign off = maddr_i[OFF_W-1:0];

   mem_stage_bus_load_align #(
      .DATA_W (DATA_W),
      .OFF_W  (OFF_W)
   ) u_load_align (
      .ld_buf  (ld_buf),
      .off     (off),
      .memop   (memop_i),
      .ld_data (ld_data)
   );

   // Access decode: size, alignment, byte lanes and lane-replicated store data.
   always_comb begin
      size          = memop_size(memop_i);
      mem_op        = is_mem_op(memop_i);
      word_off      = off;
      word_off[1:0] = 2'b00;
      misalign      = ((size == SZ_HALF) && off[0]) ||
                      ((size == SZ_WORD) && (off[1:0] != 2'b00));
      case (size)
         SZ_BYTE: begin
            sel_calc   = SEL_W'(1) << off;
            wdata_calc = {SEL_W{sdata_i[7:0]}};
         end
         SZ_HALF: begin
            sel_calc   = SEL_W'(3) << off;
            wdata_calc = {(SEL_W / 2){sdata_i[15:0]}};
         end
         default: begin
            sel_calc   = SEL_W'(15) << word_off;
            wdata_calc = {(SEL_W / 4){sdata_i[31:0]}};
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst == RstEnable) state <= ST_IDLE;
      else                  state <= state_nxt;
   end

   // Next-state and write-back/stall/exception outputs.
   always_comb begin
      state_nxt  = state;
      issue      = 1'b0;
      ack_take   = 1'b0;
      tmo_hit    = 1'b0;
      wd_o       = wd_i;
      wreg_o     = 1'b0;
      wdata_o    = wdata_i;
      stallreq_o = 1'b0;
      excpt_o    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!mem_op) begin
               wreg_o = wreg_i;
            end else if (misalign) begin
               excpt_o = 1'b1;
            end else begin
               stallreq_o = 1'b1;
               issue      = 1'b1;
               state_nxt  = ST_BUSY;
            end
         end
         ST_BUSY: begin
            stallreq_o = 1'b1;
            if (mem_ack_i) begin
               ack_take  = 1'b1;
               state_nxt = ST_DONE;
            end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
               tmo_hit   = 1'b1;
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
            if (err) begin
               excpt_o = 1'b1;
            end else if (is_load_op(memop_i)) begin
               wreg_o  = wreg_i;
               wdata_o = ld_data;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (rst == RstEnable) begin
         state_nxt  = ST_IDLE;
         issue      = 1'b0;
         ack_take   = 1'b0;
         tmo_hit    = 1'b0;
         wd_o       = '0;
         wreg_o     = 1'b0;
         wdata_o    = '0;
         stallreq_o = 1'b0;
         excpt_o    = 1'b0;
      end
   end

   // Bus request registers, timeout counter, load buffer and error flag.
   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_sel_o   <= '0;
         mem_wdata_o <= '0;
         ld_buf      <= '0;
         cnt         <= '0;
         err         <= 1'b0;
      end else begin
         if (issue) begin
            mem_req_o   <= 1'b1;
            mem_we_o    <= !is_load_op(memop_i);
            mem_addr_o  <= {maddr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            mem_sel_o   <= sel_calc;
            mem_wdata_o <= wdata_calc;
            cnt         <= '0;
            err         <= 1'b0;
         end
         if (state == ST_BUSY) begin
            cnt <= cnt + CNT_W'(1);
         end
         if (ack_take) begin
            ld_buf    <= mem_rdata_i;
            mem_req_o <= 1'b0;
            err       <= 1'b0;
         end else if (tmo_hit) begin
            mem_req_o <= 1'b0;
            err       <= 1'b1;
         end
      end
   end

endmodule
